// File: rtl/clk_divider_bank.sv
// Bank of NUM_CH programmable 50%-duty clock dividers with a single-slot valid/ready config port.
// Optional macro CLK_DIV_SYNC_EN adds sync_pulse for phase-aligning all channels.

module clk_div_chan #(
    parameter int              CNT_W        = 26,
    parameter logic [CNT_W-1:0] DEFAULT_HALF = CNT_W'(2**25 - 1),
    parameter logic            RESET_EN     = 1'b1
) (
    input  logic             clk_100mhz,
    input  logic             rst_n,
    input  logic             sync,
    input  logic             req,
    input  logic [CNT_W-1:0] req_half,
    input  logic             req_en,
    output logic             ack,
    output logic             clk_out,
    output logic             tick
);
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] half;
    logic             en;
    logic             term;

    assign term = (count == half);
    // Updates land only where the output is (or is forced) low: disabled, synced, or the falling edge.
    assign ack  = req && (!en || sync || (term && clk_out));

    always_ff @(posedge clk_100mhz) begin
        if (!rst_n) begin
            count   <= '0;
            half    <= DEFAULT_HALF;
            en      <= RESET_EN;
            clk_out <= 1'b0;
            tick    <= 1'b0;
        end else if (ack) begin
            half    <= req_half;
            en      <= req_en;
            count   <= '0;
            clk_out <= 1'b0;
            tick    <= 1'b0;
        end else if (!en || sync) begin
            count   <= '0;
            clk_out <= 1'b0;
            tick    <= 1'b0;
        end else if (term) begin
            count   <= '0;
            clk_out <= ~clk_out;
            tick    <= ~clk_out;
        end else begin
            count   <= count + CNT_W'(1);
            tick    <= 1'b0;
        end
    end
endmodule

module clk_divider_bank #(
    parameter int                NUM_CH        = 4,
    parameter int                CNT_W         = 26,
    parameter logic [CNT_W-1:0]  DEFAULT_HALF  = CNT_W'(2**25 - 1),
    parameter logic [NUM_CH-1:0] RESET_EN_MASK = {NUM_CH{1'b1}},
    localparam int               CH_W          = $clog2(NUM_CH) + 1
) (
    input  logic              clk_100mhz,
    input  logic              rst_n,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_half,
    input  logic              cfg_en,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick
`ifdef CLK_DIV_SYNC_EN
   ,input  logic              sync_pulse
`endif
);
    localparam logic [CH_W-1:0] NUM_CH_L = CH_W'(NUM_CH);

    logic              sync;
    logic              pend_vld;
    logic [CH_W-1:0]   pend_ch;
    logic [CNT_W-1:0]  pend_half;
    logic              pend_en;
    logic [NUM_CH-1:0] ack;
    logic              xfer;
    logic              ch_ok;

`ifdef CLK_DIV_SYNC_EN
    assign sync = sync_pulse;
`else
    assign sync = 1'b0;
`endif

    assign xfer  = cfg_valid && cfg_ready;
    assign ch_ok = (cfg_ch < NUM_CH_L);

    // Out-of-range requests complete the handshake but never occupy the slot.
    always_ff @(posedge clk_100mhz) begin
        if (!rst_n) begin
            pend_vld  <= 1'b0;
            pend_ch   <= '0;
            pend_half <= '0;
            pend_en   <= 1'b0;
            cfg_ready <= 1'b0;
        end else if (xfer && ch_ok) begin
            pend_vld  <= 1'b1;
            pend_ch   <= cfg_ch;
            pend_half <= cfg_half;
            pend_en   <= cfg_en;
            cfg_ready <= 1'b0;
        end else if (|ack) begin
            pend_vld  <= 1'b0;
            cfg_ready <= 1'b1;
        end else if (!pend_vld) begin
            cfg_ready <= 1'b1;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        clk_div_chan #(
            .CNT_W       (CNT_W),
            .DEFAULT_HALF(DEFAULT_HALF),
            .RESET_EN    (RESET_EN_MASK[i])
        ) u_ch (
            .clk_100mhz(clk_100mhz),
            .rst_n     (rst_n),
            .sync      (sync),
            .req       (pend_vld && (pend_ch == CH_W'(i))),
            .req_half  (pend_half),
            .req_en    (pend_en),
            .ack       (ack[i]),
            .clk_out   (clk_out[i]),
            .tick      (tick[i])
        );
    end
endmodule

// File: tb/tb_clk_divider_bank.sv
// Bench for clk_divider_bank: expected tick cycles are queued per channel by the stimulus
// and a negedge monitor pops and compares each observed tick; level checks cover handshake and outputs.

module tb_clk_divider_bank;
    localparam int NUM_CH = 4;
    localparam int CNT_W  = 8;
    localparam int CH_W   = $clog2(NUM_CH) + 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cfg_valid = 1'b0;
    logic              cfg_ready;
    logic [CH_W-1:0]   cfg_ch = '0;
    logic [CNT_W-1:0]  cfg_half = '0;
    logic              cfg_en = 1'b0;
    logic [NUM_CH-1:0] clk_out;
    logic [NUM_CH-1:0] tick;
`ifdef CLK_DIV_SYNC_EN
    logic              sync_pulse = 1'b0;
`endif

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int exp_q[NUM_CH][$];

    clk_divider_bank #(
        .NUM_CH      (NUM_CH),
        .CNT_W       (CNT_W),
        .DEFAULT_HALF(8'd3)
    ) dut (
        .clk_100mhz(clk),
        .rst_n     (rst_n),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_half  (cfg_half),
        .cfg_en    (cfg_en),
        .clk_out   (clk_out),
        .tick      (tick)
`ifdef CLK_DIV_SYNC_EN
       ,.sync_pulse(sync_pulse)
`endif
    );

    always #5 clk = ~clk;

    // cyc = number of clock edges since reset release
    always @(posedge clk) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (tick[i]) begin
                checks++;
                if (exp_q[i].size() == 0) begin
                    failures++;
                    $display("FAIL tick_ch%0d: unexpected tick at cycle %0d, none required", i, cyc);
                end else begin
                    int e;
                    e = exp_q[i].pop_front();
                    if (e != cyc) begin
                        failures++;
                        $display("FAIL tick_ch%0d: got tick at cycle %0d, required cycle %0d", i, cyc, e);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        int guard;
        guard = 0;
        while (cyc < n && guard < 1000) begin
            @(posedge clk); #1;
            guard++;
        end
    endtask

    task automatic send_cfg(input int ch, input int half, input logic en);
        cfg_valid = 1'b1;
        cfg_ch    = CH_W'(ch);
        cfg_half  = CNT_W'(half);
        cfg_en    = en;
        @(posedge clk); #1;
        cfg_valid = 1'b0;
    endtask

    task automatic push_tick(input int ch, input int c);
        exp_q[ch].push_back(c);
    endtask

    task automatic chk_drained(input string name);
        for (int i = 0; i < NUM_CH; i++)
            chk($sformatf("%s_ch%0d_missing_ticks", name, i), exp_q[i].size(), 0);
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset_clk_out", int'(clk_out), 0);
        chk("reset_tick", int'(tick), 0);
        chk("reset_cfg_ready", int'(cfg_ready), 0);

        // Expected ticks up to cycle 36 (mid-run reset at edge 37)
        for (int c = 4; c <= 36; c += 8) begin
            push_tick(0, c);
            push_tick(3, c);
        end
        push_tick(1, 4);
        for (int c = 9; c <= 35; c += 2) push_tick(1, c);
        push_tick(2, 4);
        push_tick(2, 12);
        push_tick(2, 29);

        rst_n = 1'b1;
        wait_cyc(1);
        chk("ready_after_release", int'(cfg_ready), 1);

        // ch1 -> /2 while high: falls at old terminal count (cycle 8)
        wait_cyc(5);
        send_cfg(1, 0, 1'b1);
        chk("ch1_ready_low_after_xfer", int'(cfg_ready), 0);
        wait_cyc(7);
        chk("ch1_still_high_pending", int'(clk_out[1]), 1);
        chk("ch1_ready_low_pending", int'(cfg_ready), 0);
        wait_cyc(8);
        chk("ch1_fall_at_apply", int'(clk_out[1]), 0);
        chk("ch1_ready_after_apply", int'(cfg_ready), 1);
        wait_cyc(9);
        chk("ch1_div2_rise", int'(clk_out[1]), 1);

        // ch2 disable: applies at falling edge 16, stays low
        send_cfg(2, 3, 1'b0);
        wait_cyc(15);
        chk("ch2_ready_low_pending", int'(cfg_ready), 0);
        chk("ch2_high_before_apply", int'(clk_out[2]), 1);
        wait_cyc(16);
        chk("ch2_low_after_apply", int'(clk_out[2]), 0);
        chk("ch2_ready_after_apply", int'(cfg_ready), 1);

        // ch2 re-enable half=9: transfer edge 18, apply edge 19, first rise edge 29
        wait_cyc(17);
        send_cfg(2, 9, 1'b1);
        wait_cyc(19);
        chk("ch2_reenable_ready", int'(cfg_ready), 1);
        wait_cyc(20);
        chk("ch2_low_while_counting", int'(clk_out[2]), 0);

        // Out-of-range channel: dropped, ready stays high
        send_cfg(7, 0, 1'b0);
        chk("bad_ch_ready_stays", int'(cfg_ready), 1);
        wait_cyc(29);
        chk("ch2_first_rise", int'(clk_out[2]), 1);

        // Pending on ch0 then reset before it applies
        wait_cyc(33);
        send_cfg(0, 0, 1'b1);
        chk("ch0_ready_low_pending", int'(cfg_ready), 0);
        wait_cyc(36);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("midreset_clk_out", int'(clk_out), 0);
        chk("midreset_tick", int'(tick), 0);
        chk("midreset_cfg_ready", int'(cfg_ready), 0);
        chk_drained("pre_reset");

        for (int i = 0; i < NUM_CH; i++) begin
            push_tick(i, 4);
            push_tick(i, 12);
        end
        rst_n = 1'b1;
        wait_cyc(1);
        chk("post_reset_ready", int'(cfg_ready), 1);
        wait_cyc(5);
        chk("post_reset_default_half", int'(clk_out), 15);
        wait_cyc(9);
        chk("post_reset_falls", int'(clk_out), 0);

`ifdef CLK_DIV_SYNC_EN
        wait_cyc(14);
        for (int i = 0; i < NUM_CH; i++) push_tick(i, 19);
        sync_pulse = 1'b1;
        @(posedge clk); #1;
        sync_pulse = 1'b0;
        chk("sync_all_low", int'(clk_out), 0);
        wait_cyc(19);
        chk("sync_rise_together", int'(clk_out), 15);
        wait_cyc(22);
`else
        wait_cyc(16);
`endif
        chk_drained("final");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
